// File: rtl/amp_window_stat_if.sv
// Sample/statistics bundle between the FIR magnitude source and the window statistics block.
interface amp_window_stat_if #(
  parameter int DIN_WIDTH = 55,
  parameter int OUT_WIDTH = 12
);
  logic [DIN_WIDTH-1:0] din;
  logic                 din_valid;
  logic                 enable;
  logic                 clear;
  logic [OUT_WIDTH-1:0] pk_out;
  logic [OUT_WIDTH-1:0] vl_out;
  logic [OUT_WIDTH-1:0] pp_out;
  logic [OUT_WIDTH-1:0] mean_out;
  logic                 sat_out;
  logic                 stat_valid;
  logic                 busy;

  modport master (
    output din, din_valid, enable, clear,
    input  pk_out, vl_out, pp_out, mean_out, sat_out, stat_valid, busy
  );

  modport slave (
    input  din, din_valid, enable, clear,
    output pk_out, vl_out, pp_out, mean_out, sat_out, stat_valid, busy
  );
endinterface

// File: rtl/amp_window_stat.sv
// Slices the rectified FIR magnitude to an amplitude sample and reports peak, valley,
// peak-to-peak, mean and saturation over consecutive windows of 2^WIN_LOG2 valid samples.
module amp_window_stat #(
  parameter int DIN_WIDTH = 55,
  parameter int SLICE_LSB = 34,
  parameter int OUT_WIDTH = 12,
  parameter int WIN_LOG2  = 8
) (
  input logic              clk1,
  input logic              rst_n,
  amp_window_stat_if.slave bus
);
  localparam int SUM_W  = OUT_WIDTH + WIN_LOG2;
  localparam int HI_LSB = SLICE_LSB + OUT_WIDTH;
  localparam logic [WIN_LOG2:0] WIN_LEN = {1'b1, {WIN_LOG2{1'b0}}};

  typedef enum logic {ST_FIRST, ST_ACC} state_e;

  state_e               state_q, state_d;
  logic [WIN_LOG2:0]    count_q, count_d;
  logic                 v1_q, v1_d;
  logic [OUT_WIDTH-1:0] x_q, x_d;
  logic                 s1sat_q, s1sat_d;
  logic [OUT_WIDTH-1:0] max_q, max_d, min_q, min_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic                 satacc_q, satacc_d;
  logic                 done_q, done_d;
  logic [OUT_WIDTH-1:0] pk_q, pk_d, vl_q, vl_d, pp_q, pp_d, mean_q, mean_d;
  logic                 sat_q, sat_d, sv_q, sv_d;

  logic                 hi_sat;
  logic [OUT_WIDTH-1:0] x_in;
  logic                 unused_lo;
  logic [OUT_WIDTH-1:0] nmax, nmin;
  logic [SUM_W-1:0]     nsum;
  logic                 nsat;
  logic [WIN_LOG2:0]    ncount;

  assign hi_sat    = |bus.din[DIN_WIDTH-1:HI_LSB];
  assign x_in      = hi_sat ? '1 : bus.din[HI_LSB-1:SLICE_LSB];
  assign unused_lo = ^bus.din[SLICE_LSB-1:0];

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q  <= ST_FIRST;
      count_q  <= '0;
      v1_q     <= 1'b0;
      x_q      <= '0;
      s1sat_q  <= 1'b0;
      max_q    <= '0;
      min_q    <= '0;
      sum_q    <= '0;
      satacc_q <= 1'b0;
      done_q   <= 1'b0;
      pk_q     <= '0;
      vl_q     <= '0;
      pp_q     <= '0;
      mean_q   <= '0;
      sat_q    <= 1'b0;
      sv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      v1_q     <= v1_d;
      x_q      <= x_d;
      s1sat_q  <= s1sat_d;
      max_q    <= max_d;
      min_q    <= min_d;
      sum_q    <= sum_d;
      satacc_q <= satacc_d;
      done_q   <= done_d;
      pk_q     <= pk_d;
      vl_q     <= vl_d;
      pp_q     <= pp_d;
      mean_q   <= mean_d;
      sat_q    <= sat_d;
      sv_q     <= sv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    x_d      = x_q;
    s1sat_d  = s1sat_q;
    max_d    = max_q;
    min_d    = min_q;
    sum_d    = sum_q;
    satacc_d = satacc_q;
    pk_d     = pk_q;
    vl_d     = vl_q;
    pp_d     = pp_q;
    mean_d   = mean_q;
    sat_d    = sat_q;
    done_d   = 1'b0;
    sv_d     = 1'b0;
    nmax     = x_q;
    nmin     = x_q;
    nsum     = {{WIN_LOG2{1'b0}}, x_q};
    nsat     = s1sat_q;
    ncount   = {{WIN_LOG2{1'b0}}, 1'b1};

    v1_d = bus.din_valid & bus.enable & ~bus.clear;
    if (v1_d) begin
      x_d     = x_in;
      s1sat_d = hi_sat;
    end

    // Completed window sits in the accumulators for one cycle before being published,
    // so a clear arriving in that cycle still suppresses the strobe.
    if (done_q && !bus.clear) begin
      pk_d   = max_q;
      vl_d   = min_q;
      pp_d   = max_q - min_q;
      mean_d = sum_q[SUM_W-1:WIN_LOG2];
      sat_d  = satacc_q;
      sv_d   = 1'b1;
    end

    if (bus.clear) begin
      state_d = ST_FIRST;
      count_d = '0;
    end else if (v1_q) begin
      if (state_q == ST_ACC) begin
        nmax   = (x_q > max_q) ? x_q : max_q;
        nmin   = (x_q < min_q) ? x_q : min_q;
        nsum   = sum_q + {{WIN_LOG2{1'b0}}, x_q};
        nsat   = satacc_q | s1sat_q;
        ncount = count_q + 1'b1;
      end
      max_d    = nmax;
      min_d    = nmin;
      sum_d    = nsum;
      satacc_d = nsat;
      if (ncount == WIN_LEN) begin
        state_d = ST_FIRST;
        count_d = '0;
        done_d  = 1'b1;
      end else begin
        state_d = ST_ACC;
        count_d = ncount;
      end
    end
  end

  assign bus.pk_out     = pk_q;
  assign bus.vl_out     = vl_q;
  assign bus.pp_out     = pp_q;
  assign bus.mean_out   = mean_q;
  assign bus.sat_out    = sat_q;
  assign bus.stat_valid = sv_q;
  assign bus.busy       = (state_q == ST_ACC) || v1_q;
endmodule

// File: doc/amp_window_stat.md
Name: amp_window_stat

Overview:
- Consumes the magnitude stream of the FIR filter stage: the rectified filter output word plus its one-cycle valid pulse.
- Slices that word to a fixed-width amplitude sample. Over consecutive windows of 2^WIN_LOG2 valid samples it computes the peak, valley, peak-to-peak and mean.
- Presents one registered statistics record per window with a one-cycle strobe, for the stability/readout logic.

Parameters:
DIN_WIDTH, 55, width of incoming filter magnitude word (MSB is always 0 after rectification)
SLICE_LSB, 34, LSB position of the amplitude slice within din
OUT_WIDTH, 12, width of sliced sample and of every statistic output
WIN_LOG2, 8, log2 of window length in valid samples (window = 256); legal range 1..16

Ports:
clk1  in  1  system clock (50 MHz domain of the filter stage)
rst_n  in  1  synchronous active-low reset
din  in  DIN_WIDTH  rectified filter magnitude
din_valid  in  1  one-cycle qualifier for din; gaps of any length allowed
enable  in  1  1 = accept samples; 0 = pause, partial window held
clear  in  1  synchronous restart of the current window
pk_out  out  OUT_WIDTH  maximum sliced sample of the last completed window
vl_out  out  OUT_WIDTH  minimum sliced sample of the last completed window
pp_out  out  OUT_WIDTH  pk_out - vl_out
mean_out  out  OUT_WIDTH  window sum >> WIN_LOG2 (truncating)
sat_out  out  1  1 if any sample in the last window saturated
stat_valid  out  1  one-cycle strobe: all stat outputs updated this cycle
busy  out  1  1 while a window is partially accumulated

Behaviour:
- Reset (rst_n=0 at a clk1 edge): state=FIRST, count=0. All outputs, the stage-1 register and accumulators are 0; stat_valid=0, busy=0.
- Stage 1 (slice/saturate), registered. Captures when din_valid and enable are both 1.
  - x = din[SLICE_LSB+OUT_WIDTH-1:SLICE_LSB].
  - If any din bit above SLICE_LSB+OUT_WIDTH-1 is 1: x = all ones and sat bit = 1.
  - Bits below SLICE_LSB are discarded (truncation).
  - v1 = 1 for one cycle.
- Stage 2 (accumulate), acts on v1.
  - State FIRST: max=min=x, sum=x (OUT_WIDTH+WIN_LOG2 bits, cannot overflow), sat_acc=sat bit, count=1, go to ACC.
    - If WIN_LOG2 window length were 1 this would also complete; WIN_LOG2>=1 makes the window length >=2, so not applicable.
  - State ACC: max=max(max,x), min=min(min,x), sum+=x, sat_acc|=sat bit, count+=1.
  - When the current v1 is sample number 2^WIN_LOG2:
    - Register outputs from the values including x: pk=max, vl=min, pp=max-min (never negative), mean=sum>>WIN_LOG2, sat.
    - Pulse stat_valid for exactly one cycle.
    - Return to FIRST and reset count to 0.
- Latency: the final sample's din_valid is sampled at edge k. stat_valid and the new outputs are visible after edge k+2 for one cycle. Outputs then hold until the next window completes.
- busy = (state==ACC) or v1 pending.
- enable=0:
  - din_valid ignored.
  - A sample already in stage 1 still accumulates.
  - count, max, min and sum are held; accumulation resumes when enable returns to 1.
- clear=1 (sync):
  - Flushes v1, returns to FIRST, count=0.
  - No stat_valid; stat outputs keep their previous values.
  - clear together with din_valid in the same cycle: clear wins, the sample is dropped.
  - clear in the same cycle a window would complete: clear wins, no strobe.
- rst_n low mid-window: identical to reset. Partial window lost; outputs zeroed.
- Back-to-back valids (every cycle) are fully supported. The window after a completion starts with the very next valid sample, without gaps.
- Counter wrap: count is WIN_LOG2+1 bits and never exceeds 2^WIN_LOG2.

Test Plan:
- Reset: drive rst_n=0 with random din/din_valid -> every output 0, stat_valid 0, busy 0 for the whole reset.
- WIN_LOG2=2, slices 10, 20, 5, 15 on non-consecutive valids -> 2 cycles after the 4th valid: pk=20, vl=5, pp=15, mean=12, sat=0, stat_valid high exactly 1 cycle.
- Saturation, WIN_LOG2=2: one sample with din[46]=1, others slice 100 -> pk=4095, vl=100, pp=3995, mean=(4095+300)>>2=1098, sat=1.
- Clear, WIN_LOG2=2: 2 samples of slice 50, then clear coincident with a valid, then samples 1, 2, 3, 4 -> single strobe with pk=4, vl=1, pp=3, mean=2.
- Enable pause and continuous valids, WIN_LOG2=2: 8 valids every cycle with enable=0 during samples 3-4 (those two dropped), slices 1..8 -> first window {1,2,5,6}: pk=6, vl=1, mean=3. Second window incomplete, busy=1.
- Reset mid-window: 3 of 4 samples, rst_n low 1 cycle, then 4 samples of 7 -> outputs 0 after reset, then pk=vl=mean=7, pp=0.
